fetch_stage: RTL

//  Instruction-fetch stage: PC register, instruction-memory request/ready handshake
//  and the IF/ID pipeline register. Consumes pcwrite/if_id_write from the load-use

---
 rtl/pipeline_pkg.sv | 7 +
 rtl/fetch_stage_if.sv | 13 +
 rtl/fetch_stage_if_id_reg.sv | 34 +++
 rtl/fetch_stage.sv | 87 ++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch-stage state type.
package pipeline_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic {FETCH, REDIR} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready handshake between fetch stage and memory.
interface fetch_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic [INSTR_W-1:0] rdata;
  logic               ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats bubble/load.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write,
  input  logic               flush,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc4_d,
  output logic [INSTR_W-1:0] instr_q,
  output logic [PC_W-1:0]    pc4_q,
  output logic               valid_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush || (write && bubble)) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (write) begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= 1'b1;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, redirect tracking across outstanding fetches, IF/ID.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pcwrite,
  input  logic               if_id_write,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid
);
  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc, pc_n, pend_pc, pend_n;
  logic [PC_W-1:0] target, pc_plus4;
  logic            load;

  assign target   = branch_target & ~PC_W'(3);
  assign pc_plus4 = pc + PC_W'(PC_INC);

  assign imem.req  = !rst;
  assign imem.addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
    end
  end

  // pcwrite=1 with if_id_write=0 falls through to "hold": the PC never
  // advances past a word that IF/ID cannot accept.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    load    = 1'b0;
    case (state)
      FETCH: begin
        if (imem.ready) begin
          if (branch_taken) begin
            pc_n = target;
          end else if (pcwrite && if_id_write) begin
            pc_n = pc_plus4;
            load = 1'b1;
          end
        end else if (branch_taken) begin
          pend_n  = target;
          state_n = REDIR;
        end
      end
      REDIR: begin
        if (branch_taken) pend_n = target;
        if (imem.ready) begin
          pc_n    = branch_taken ? target : pend_pc;
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  if_id_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .write   (if_id_write),
    .flush   (branch_taken),
    .bubble  (!load),
    .instr_d (imem.rdata),
    .pc4_d   (pc_plus4),
    .instr_q (if_id_instr),
    .pc4_q   (if_id_pc4),
    .valid_q (if_id_valid)
  );
endmodule
